// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, branch flush and multi-cycle
// data-memory freeze for the 5-stage core, with saturating stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              branch_taken_i,
    input  logic              mem_req_i,
    input  logic              mem_ack_i,
    output logic              pc_write_o,
    output logic              if_stall_o,
    output logic              if_flush_o,
    output logic              bubble_o,
    output logic              freeze_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;
    logic   hazard;
    logic   active;
    logic   stall_evt;

    assign hazard = ex_memread_i && (ex_rd_i != '0) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs act on the pipeline registers in the same cycle, so they are decoded here.
    always_comb begin
        state_nxt  = state;
        pc_write_o = 1'b0;
        if_stall_o = 1'b0;
        if_flush_o = 1'b0;
        bubble_o   = 1'b0;
        freeze_o   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (mem_req_i && !mem_ack_i) begin
                    freeze_o   = 1'b1;
                    if_stall_o = 1'b1;
                    state_nxt  = MEM_WAIT;
                end else if (hazard) begin
                    // Hazard wins over a taken branch; ID is held so the branch re-resolves.
                    if_stall_o = 1'b1;
                    bubble_o   = 1'b1;
                end else if (branch_taken_i) begin
                    pc_write_o = 1'b1;
                    if_flush_o = 1'b1;
                end else begin
                    pc_write_o = 1'b1;
                end
                if (!start_i) begin
                    state_nxt = IDLE;
                end
            end
            MEM_WAIT: begin
                freeze_o   = 1'b1;
                if_stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_nxt = RUN;
                end
                if (!start_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign active    = (state == RUN) || (state == MEM_WAIT);
    assign stall_evt = active && !pc_write_o;

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_evt && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (if_flush_o && (flush_cnt_o != CNT_MAX)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic, checked every
// cycle against a rule-level model; a second instance with 4-bit counters checks saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic       start = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, ex_rd = '0;
    logic       ex_memread = 1'b0, branch = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;

    logic        pc_write, if_stall, if_flush, bubble, freeze;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_write4, if_stall4, if_flush4, bubble4, freeze4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    // Model: mode 0 = stopped, 1 = running, 2 = waiting on memory; counters unbounded.
    int m_mode = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst_i(rst_i), .start_i(start),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
        .branch_taken_i(branch), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_write_o(pc_write), .if_stall_o(if_stall), .if_flush_o(if_flush),
        .bubble_o(bubble), .freeze_o(freeze),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    hazard_ctrl #(.REG_AW(5), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_i(rst_i), .start_i(start),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_memread_i(ex_memread), .ex_rd_i(ex_rd),
        .branch_taken_i(branch), .mem_req_i(mem_req), .mem_ack_i(mem_ack),
        .pc_write_o(pc_write4), .if_stall_o(if_stall4), .if_flush_o(if_flush4),
        .bubble_o(bubble4), .freeze_o(freeze4),
        .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_memread = 1'b0; ex_rd = '0; rs1 = '0; rs2 = '0;
        branch = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Per-cycle compare against the rule-level model, sampled mid-cycle.
    always @(negedge clk) begin
        bit e_pc, e_stall, e_flush, e_bub, e_frz, haz;
        e_pc = 0; e_stall = 0; e_flush = 0; e_bub = 0; e_frz = 0;
        if (!rst_i) begin
            m_mode = 0; m_stall = 0; m_flush = 0;
        end
        haz = ex_memread && (ex_rd != 0) && (ex_rd == rs1 || ex_rd == rs2);
        if (m_mode == 1) begin
            if (mem_req && !mem_ack) begin e_frz = 1; e_stall = 1; end
            else if (haz)            begin e_stall = 1; e_bub = 1; end
            else if (branch)         begin e_pc = 1; e_flush = 1; end
            else                     e_pc = 1;
        end else if (m_mode == 2) begin
            e_frz = 1; e_stall = 1;
        end
        check("pc_write", int'(pc_write), int'(e_pc));
        check("if_stall", int'(if_stall), int'(e_stall));
        check("if_flush", int'(if_flush), int'(e_flush));
        check("bubble",   int'(bubble),   int'(e_bub));
        check("freeze",   int'(freeze),   int'(e_frz));
        check("freeze4",  int'(freeze4),  int'(e_frz));
        check("pc_write4", int'(pc_write4), int'(e_pc));
        check("stall_cnt",  int'(stall_cnt),  sat(m_stall, 65535));
        check("flush_cnt",  int'(flush_cnt),  sat(m_flush, 65535));
        check("stall_cnt4", int'(stall_cnt4), sat(m_stall, 15));
        check("flush_cnt4", int'(flush_cnt4), sat(m_flush, 15));
        if (rst_i) begin
            if (m_mode != 0 && !e_pc) m_stall++;
            if (e_flush) m_flush++;
            if (m_mode == 0)                         m_mode = start ? 1 : 0;
            else if (!start)                         m_mode = 0;
            else if (m_mode == 1 && mem_req && !mem_ack) m_mode = 2;
            else if (m_mode == 2 && mem_ack)         m_mode = 1;
        end
    end

    initial begin
        // Reset and start-up
        clear_inputs();
        repeat (3) step();
        rst_i = 1'b1;
        #1;
        check("rst_pc_write", int'(pc_write), 0);
        check("rst_freeze", int'(freeze), 0);
        check("rst_stall_cnt", int'(stall_cnt), 0);
        check("rst_flush_cnt", int'(flush_cnt), 0);
        step();
        check("idle_pc_write", int'(pc_write), 0);
        start = 1'b1;
        step();
        check("run_pc_write", int'(pc_write), 1);

        // Load-use hazard, then rd=0 which must not stall
        ex_memread = 1'b1; ex_rd = 5'd5; rs1 = 5'd1; rs2 = 5'd5;
        #1;
        check("lu_pc_write", int'(pc_write), 0);
        check("lu_if_stall", int'(if_stall), 1);
        check("lu_bubble", int'(bubble), 1);
        step();
        clear_inputs();
        #1;
        check("lu_stall_cnt", int'(stall_cnt), 1);
        ex_memread = 1'b1; ex_rd = 5'd0; rs1 = 5'd0;
        #1;
        check("rd0_pc_write", int'(pc_write), 1);
        step();
        clear_inputs();

        // Taken branch, then branch under a concurrent hazard
        branch = 1'b1;
        #1;
        check("br_if_flush", int'(if_flush), 1);
        check("br_pc_write", int'(pc_write), 1);
        step();
        branch = 1'b0;
        #1;
        check("br_flush_cnt", int'(flush_cnt), 1);
        branch = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; rs1 = 5'd7;
        #1;
        check("brhz_if_flush", int'(if_flush), 0);
        check("brhz_if_stall", int'(if_stall), 1);
        step();
        clear_inputs();
        #1;
        check("brhz_flush_cnt", int'(flush_cnt), 1);
        check("brhz_stall_cnt", int'(stall_cnt), 2);

        // Multi-cycle memory access: ack after three waiting cycles
        mem_req = 1'b1;
        #1;
        check("mem_freeze0", int'(freeze), 1);
        step();
        check("mem_freeze1", int'(freeze), 1);
        step();
        check("mem_freeze2", int'(freeze), 1);
        step();
        mem_ack = 1'b1;
        #1;
        check("mem_freeze3", int'(freeze), 1);
        step();
        clear_inputs();
        #1;
        check("mem_done_freeze", int'(freeze), 0);
        check("mem_done_pc_write", int'(pc_write), 1);
        check("mem_stall_cnt", int'(stall_cnt), 6);
        mem_req = 1'b1; mem_ack = 1'b1;
        #1;
        check("zw_freeze", int'(freeze), 0);
        check("zw_pc_write", int'(pc_write), 1);
        step();
        clear_inputs();

        // Reset in the middle of a memory wait
        mem_req = 1'b1;
        step();
        mem_req = 1'b0;
        #1;
        check("mw_freeze", int'(freeze), 1);
        rst_i = 1'b0;
        #1;
        check("arst_freeze", int'(freeze), 0);
        check("arst_stall_cnt", int'(stall_cnt), 0);
        check("arst_flush_cnt", int'(flush_cnt), 0);
        step();
        rst_i = 1'b1;
        #1;
        check("arst_idle_pc_write", int'(pc_write), 0);
        step();

        // Held load-use: 4-bit counter saturates, 16-bit keeps counting
        ex_memread = 1'b1; ex_rd = 5'd3; rs1 = 5'd3;
        repeat (20) step();
        check("sat_stall_cnt4", int'(stall_cnt4), 15);
        check("sat_stall_cnt", int'(stall_cnt), 20);
        clear_inputs();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_i      = ($urandom_range(0, 199) != 0);
            start      = ($urandom_range(0, 49) != 0);
            ex_memread = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 3));
            rs1        = 5'($urandom_range(0, 3));
            rs2        = 5'($urandom_range(0, 3));
            branch     = ($urandom_range(0, 3) == 0);
            mem_req    = ($urandom_range(0, 4) == 0);
            mem_ack    = ($urandom_range(0, 2) == 0);
        end
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
